// File: rtl/uart_pkg.sv
// Shared UART definitions: clocking defaults, frame geometry, line levels and TX state encoding.
// Also used by the matching receiver so both ends agree on line polarity.
package uart_pkg;

    localparam int c_CLK_HZ             = 50000000;
    localparam int c_BAUD               = 115200;
    localparam int c_CYCLES_PER_BIT_DEF = 434;
    localparam int c_DATA_BITS          = 8;

    localparam logic c_IDLE_LVL  = 1'b1;
    localparam logic c_START_LVL = 1'b0;

    localparam logic [1:0] c_TX_IDLE  = 2'd0;
    localparam logic [1:0] c_TX_START = 2'd1;
    localparam logic [1:0] c_TX_DATA  = 2'd2;
    localparam logic [1:0] c_TX_STOP  = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = c_TX_IDLE,
        TX_START = c_TX_START,
        TX_DATA  = c_TX_DATA,
        TX_STOP  = c_TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: counts 0..c_CYCLES-1, ticks on the last count and wraps.
// clear_i forces the count back to 0 on the following cycle.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int c_CYCLES = c_CYCLES_PER_BIT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int             c_W    = (c_CYCLES > 1) ? $clog2(c_CYCLES) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(c_CYCLES - 1);

    logic [c_W-1:0] cnt_q;
    logic [c_W-1:0] cnt_d;

    assign tick_o = (cnt_q == c_LAST);

    always_comb begin
        cnt_d = cnt_q + c_W'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so frames can run back-to-back.
// Line, active and done are all registered from the FSM state, so they stay mutually aligned.
module uart_tx
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_CYCLES_PER_BIT_DEF,
    parameter int c_STOP_BITS      = 1
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic [7:0] i_TX_DATA,
    input  logic       i_TX_DV,
    output logic       o_TX_READY,
    output logic       o_SERIAL_DATA,
    output logic       o_TX_ACTIVE,
    output logic       o_TX_DONE
);

    localparam logic c_LAST_STOP = 1'(c_STOP_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       serial_q, serial_d;
    logic       active_q, active_d;
    logic       done_q, done_d;

    logic       tick;
    logic       timer_clr;
    logic       accept;
    logic       load;

    assign o_TX_READY    = !hold_vld_q;
    assign o_SERIAL_DATA = serial_q;
    assign o_TX_ACTIVE   = active_q;
    assign o_TX_DONE     = done_q;

    assign accept = i_TX_DV && !hold_vld_q;

    // Every state entry restarts the bit period; IDLE keeps the timer parked at 0.
    assign timer_clr = (state_d != state_q) || (state_q == TX_IDLE);

    uart_bit_timer #(
        .c_CYCLES (c_CYCLES_PER_BIT)
    ) u_bit_timer (
        .clk_i   (i_CLK),
        .rst_ni  (i_RESET),
        .clear_i (timer_clr),
        .tick_o  (tick)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        done_d     = 1'b0;
        load       = 1'b0;

        if (accept) begin
            hold_d     = i_TX_DATA;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            TX_IDLE: begin
                if (hold_vld_q) begin
                    load = 1'b1;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_d   = TX_DATA;
                    bit_idx_d = '0;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'(c_DATA_BITS - 1)) begin
                        state_d    = TX_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (stop_idx_q == c_LAST_STOP) begin
                        done_d = 1'b1;
                        // A waiting byte goes straight into the next start bit.
                        if (hold_vld_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (load) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            bit_idx_d  = '0;
            state_d    = TX_START;
        end
    end

    always_comb begin
        serial_d = c_IDLE_LVL;
        case (state_q)
            TX_START: serial_d = c_START_LVL;
            TX_DATA:  serial_d = shift_q[0];
            default:  serial_d = c_IDLE_LVL;
        endcase
        active_d = (state_q != TX_IDLE);
    end

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q    <= TX_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            serial_q   <= c_IDLE_LVL;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: handshake driver pushes accepted bytes into a queue; a line monitor
// rebuilds each expected frame waveform from the byte and compares it cycle by cycle.
module tb_uart_tx;

    localparam int CPB   = 16;
    localparam int NSTOP = 2;
    localparam int FRAME = (9 + NSTOP) * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv    = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       serial;
    logic       active;
    logic       done;

    always #5 clk = ~clk;

    uart_tx #(
        .c_CYCLES_PER_BIT (CPB),
        .c_STOP_BITS      (NSTOP)
    ) dut (
        .i_CLK         (clk),
        .i_RESET       (rst_n),
        .i_TX_DATA     (data),
        .i_TX_DV       (dv),
        .o_TX_READY    (ready),
        .o_SERIAL_DATA (serial),
        .o_TX_ACTIVE   (active),
        .o_TX_DONE     (done)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         start_cyc[$];
    int         done_cyc[$];
    int         cyc = 0;
    int         frames_seen = 0;
    int         idle_err = 0;
    bit         in_frame = 1'b0;
    int         k = 0;
    int         ferr = 0;
    logic [7:0] cur = 8'h00;

    // Expected line level k cycles into a frame: start bit, 8 data bits LSB first, stop bits.
    function automatic logic model_line(input logic [7:0] b, input int kk);
        int j;
        j = kk / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line monitor / scoreboard consumer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                if (serial !== 1'b1 || active !== 1'b0 || done !== 1'b0) idle_err++;
            end else begin
                if (!in_frame && serial === 1'b0) begin
                    in_frame = 1'b1;
                    k        = 0;
                    ferr     = 0;
                    start_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: start bit at cycle %0d, no byte queued", cyc);
                        cur = 8'h00;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                if (in_frame) begin
                    if (serial !== model_line(cur, k)) ferr++;
                    if (done !== ((k == FRAME - 1) ? 1'b1 : 1'b0)) ferr++;
                    if (active !== 1'b1) ferr++;
                    if (k == FRAME - 1) begin
                        done_cyc.push_back(cyc);
                        tests++;
                        if (ferr != 0) begin
                            fails++;
                            $display("FAIL frame_%02h: %0d mismatching cycles, expected 0", cur, ferr);
                        end
                        in_frame = 1'b0;
                        frames_seen++;
                    end
                    k++;
                end else if (active !== 1'b0 || done !== 1'b0) begin
                    idle_err++;
                end
            end
            cyc++;
        end
    end

    // Offer a byte; while READY is low the bus carries junk (junk=1) so only the accept-edge value counts.
    task automatic send(input logic [7:0] b, input bit junk);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                data = b;
                dv   = 1'b1;
                exp_q.push_back(b);
                ok = 1'b1;
                break;
            end
            dv   = 1'b1;
            data = junk ? 8'($urandom) : b;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %02h not accepted, ready=%b", b, ready);
            dv = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        dv   = 1'b0;
        data = 8'($urandom);
    endtask

    task automatic wait_frames(input int n, input string name);
        int i;
        i = 0;
        while (frames_seen < n && i < 40 * FRAME) begin
            @(posedge clk);
            i++;
        end
        check(name, 32'(frames_seen), 32'(n));
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int i;

        // Reset state
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_serial", 32'(serial), 32'd1);
        check("rst_ready",  32'(ready),  32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done",   32'(done),   32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte and accept-to-start-bit latency
        send(8'h26, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("lat_after_n1", 32'(serial), 32'd1);
        @(negedge clk);
        check("lat_after_n2", 32'(serial), 32'd0);
        wait_frames(1, "single_frames");

        // Back-to-back frames
        base = frames_seen;
        send(8'hA5, 1'b0);
        send(8'h3C, 1'b0);
        wait_frames(base + 2, "b2b_frames");
        check("b2b_start_gap",
              32'(start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2]), 32'(FRAME));
        check("b2b_done_gap",
              32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'(FRAME));

        // Random bytes, random gaps, junk on the bus during backpressure
        base = frames_seen;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 3) == 3) repeat ($urandom_range(1, 2 * FRAME)) @(negedge clk);
            send(8'($urandom), 1'b1);
        end
        wait_frames(base + 16, "rand_frames");

        // Reset during data bit 4 of 0xFF with a second byte waiting in the holding register
        base = frames_seen;
        send(8'hFF, 1'b0);
        send(8'h81, 1'b0);
        i = 0;
        while (!(in_frame && k >= 5 * CPB + CPB / 2) && i < 4 * FRAME) begin
            @(posedge clk);
            i++;
        end
        check("midframe_reached", 32'(in_frame && k >= 5 * CPB + CPB / 2), 32'd1);
        check("midframe_hold_full", 32'(ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_line",  32'(serial), 32'd1);
        check("async_rst_ready", 32'(ready),  32'd1);
        check("async_rst_done",  32'(done),   32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        check("rst_no_frame", 32'(frames_seen), 32'(base));
        send(8'h5A, 1'b0);
        wait_frames(base + 1, "post_rst_frames");

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("idle_outputs",  32'(idle_err),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
